sync_fifo: RTL and testbench

Single-clock, parametrised FIFO buffer for intra-domain rate smoothing between producer and consumer stages. It is the same-clock counterpart of the dual-clock FIFO and adds what that block lacks: level reporting, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, synchronous flush and an optional first-word-fall-through read port. Both sides share one clock, so no pointer synchronisation is needed.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_ram.sv | 28 ++
 rtl/sync_fifo.sv | 135 +++++++++++++
 tb/tb_sync_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the single-clock FIFO (sync_fifo) and its storage array.
package fifo_pkg;

  // Width used when comparing the occupancy against integer thresholds.
  localparam int LEVEL_WIDE_W = 32;
  typedef logic [LEVEL_WIDE_W-1:0] level_wide_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so that a completely full FIFO (count == depth) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level, almost flags, sticky errors and flush.
// Define SYNC_FIFO_FWFT_EN for a first-word-fall-through read port; default is a registered read.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       wr_full,
  output logic                       almost_full,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int ADDR_W = ptr_width(DEPTH);
  localparam int CNT_W  = cnt_width(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  err_flags_t            err_q, err_d;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Flags come only from registered count, so they reflect the pre-edge state.
  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // A fresh error in the same cycle as clr_err keeps the flag set.
  always_comb begin
    err_d           = err_q;
    err_d.overflow  = (err_q.overflow  & ~clr_err) | (wr_en & full  & ~flush);
    err_d.underflow = (err_q.underflow & ~clr_err) | (rd_en & empty & ~flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr_q),
    .wdata(wr_data),
    .raddr(rd_ptr_q),
    .rdata(ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is visible directly; meaningless while empty.
  assign rd_data = ram_rdata;
`else
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_acc) rd_data_d = ram_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`endif

  assign wr_full      = full;
  assign rd_empty     = empty;
  assign level        = count_q;
  assign almost_full  = (level_wide_t'(count_q) >= level_wide_t'(AF_THRESH));
  assign almost_empty = (level_wide_t'(count_q) <= level_wide_t'(AE_THRESH));
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DATA_WIDTH=8, DEPTH=4, AF=3, AE=1).
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_full;
  logic       almost_full;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_empty;
  logic       almost_empty;
  logic [2:0] level;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  int checks = 0;
  int errors = 0;

  sync_fifo #(
    .DATA_WIDTH(8),
    .DEPTH     (4),
    .AF_THRESH (3),
    .AE_THRESH (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_full     (wr_full),
    .almost_full (almost_full),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_empty    (rd_empty),
    .almost_empty(almost_empty),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_data = 8'h00;
    idle();
    tick(); tick();
    checks++;
    if ({wr_full, rd_empty, almost_empty, almost_full, overflow, underflow} !== 6'b011000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 011000",
               {wr_full, rd_empty, almost_empty, almost_full, overflow, underflow});
    end
    checks++;
    if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++;
    if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      push(vals[i]);
      checks++;
      if (level !== 3'(i + 1) || almost_full !== (i + 1 >= 3) || wr_full !== (i + 1 == 4) ||
          almost_empty !== (i + 1 <= 1) || rd_empty !== 1'b0) begin
        errors++;
        $display("FAIL fill_%0d: level=%0d af=%b full=%b ae=%b empty=%b expected level=%0d",
                 i, level, almost_full, wr_full, almost_empty, rd_empty, i + 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      checks++;
      if (rd_data !== vals[i]) begin errors++; $display("FAIL drain_data_%0d: got %h expected %h", i, rd_data, vals[i]); end
      tick();
`else
      tick();
      checks++;
      if (rd_data !== vals[i]) begin errors++; $display("FAIL drain_data_%0d: got %h expected %h", i, rd_data, vals[i]); end
`endif
      rd_en = 1'b0;
      checks++;
      if (level !== 3'(3 - i)) begin errors++; $display("FAIL drain_level_%0d: got %0d expected %0d", i, level, 3 - i); end
    end
    checks++;
    if (rd_empty !== 1'b1 || underflow !== 1'b0) begin
      errors++; $display("FAIL drain_empty: empty=%b underflow=%b expected 1 0", rd_empty, underflow);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 4; i++) push(8'h55 + 8'(i));
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h99;
`ifdef SYNC_FIFO_FWFT_EN
    checks++;
    if (rd_data !== 8'h55) begin errors++; $display("FAIL full_rw_data: got %h expected 55", rd_data); end
`endif
    tick();
    idle();
    checks++;
    if (level !== 3'd3 || overflow !== 1'b1 || underflow !== 1'b0) begin
      errors++; $display("FAIL full_rw: level=%0d ovf=%b udf=%b expected 3 1 0", level, overflow, underflow);
    end
`ifndef SYNC_FIFO_FWFT_EN
    checks++;
    if (rd_data !== 8'h55) begin errors++; $display("FAIL full_rw_data: got %h expected 55", rd_data); end
`endif
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: got %b expected 0", overflow); end
    // The rejected 0x99 must not appear in the stream.
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      checks++;
      if (rd_data !== 8'h56 + 8'(i)) begin errors++; $display("FAIL full_drain_%0d: got %h expected %h", i, rd_data, 8'h56 + 8'(i)); end
      tick();
`else
      tick();
      checks++;
      if (rd_data !== 8'h56 + 8'(i)) begin errors++; $display("FAIL full_drain_%0d: got %h expected %h", i, rd_data, 8'h56 + 8'(i)); end
`endif
      rd_en = 1'b0;
    end
  endtask

  task automatic test_empty_rw();
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77;
    tick();
    idle();
    checks++;
    if (level !== 3'd1 || underflow !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL empty_rw: level=%0d udf=%b ovf=%b expected 1 1 0", level, underflow, overflow);
    end
`ifdef SYNC_FIFO_FWFT_EN
    checks++;
    if (rd_data !== 8'h77) begin errors++; $display("FAIL empty_rw_data: got %h expected 77", rd_data); end
`else
    checks++;
    if (rd_data !== 8'h58) begin errors++; $display("FAIL empty_rw_data: got %h expected 58 (unchanged)", rd_data); end
`endif
    rd_en = 1'b1; clr_err = 1'b1;
    tick();
    idle();
    checks++;
    if (underflow !== 1'b0 || level !== 3'd0 || rd_data !== 8'h77) begin
      errors++; $display("FAIL clr_with_read: udf=%b level=%0d data=%h expected 0 0 77", underflow, level, rd_data);
    end
    rd_en = 1'b1; clr_err = 1'b1;
    tick();
    idle();
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL err_beats_clr: got %b expected 1", underflow); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL clr_underflow: got %b expected 0", underflow); end
  endtask

  task automatic test_back_to_back();
    int bad_level = 0;
    int bad_data  = 0;
    push(8'hA0);
    push(8'hA1);
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hA2 + 8'(i);
`ifdef SYNC_FIFO_FWFT_EN
      if (rd_data !== 8'hA0 + 8'(i)) bad_data++;
      tick();
`else
      tick();
      if (rd_data !== 8'hA0 + 8'(i)) bad_data++;
`endif
      if (level !== 3'd2) bad_level++;
    end
    idle();
    checks++;
    if (bad_level != 0) begin errors++; $display("FAIL b2b_level: %0d cycles off level 2, expected 0", bad_level); end
    checks++;
    if (bad_data != 0) begin errors++; $display("FAIL b2b_order: %0d data mismatches, expected 0", bad_data); end
    for (int i = 0; i < 2; i++) begin
      rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      checks++;
      if (rd_data !== 8'hAA + 8'(i)) begin errors++; $display("FAIL b2b_tail_%0d: got %h expected %h", i, rd_data, 8'hAA + 8'(i)); end
      tick();
`else
      tick();
      checks++;
      if (rd_data !== 8'hAA + 8'(i)) begin errors++; $display("FAIL b2b_tail_%0d: got %h expected %h", i, rd_data, 8'hAA + 8'(i)); end
`endif
      rd_en = 1'b0;
    end
    checks++;
    if (rd_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b expected 1", rd_empty); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
    tick();
    idle();
    checks++;
    if (level !== 3'd3 || overflow !== 1'b1) begin
      errors++; $display("FAIL pre_flush: level=%0d ovf=%b expected 3 1", level, overflow);
    end
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'hDD;
    tick();
    idle();
    checks++;
    if (level !== 3'd0 || rd_empty !== 1'b1 || almost_empty !== 1'b1 || overflow !== 1'b1 || underflow !== 1'b0) begin
      errors++; $display("FAIL flush: level=%0d empty=%b ae=%b ovf=%b udf=%b expected 0 1 1 1 0",
                         level, rd_empty, almost_empty, overflow, underflow);
    end
    push(8'h31);
    rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
    checks++;
    if (rd_data !== 8'h31) begin errors++; $display("FAIL post_flush_data: got %h expected 31", rd_data); end
    tick();
`else
    tick();
    checks++;
    if (rd_data !== 8'h31) begin errors++; $display("FAIL post_flush_data: got %h expected 31", rd_data); end
`endif
    rd_en = 1'b0;
  endtask

  task automatic test_async_reset();
    push(8'h41);
    push(8'h42);
    push(8'h43);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (level !== 3'd0 || rd_empty !== 1'b1 || almost_empty !== 1'b1 || wr_full !== 1'b0 ||
        almost_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL async_reset: level=%0d empty=%b ae=%b full=%b af=%b ovf=%b udf=%b",
                         level, rd_empty, almost_empty, wr_full, almost_full, overflow, underflow);
    end
`ifndef SYNC_FIFO_FWFT_EN
    checks++;
    if (rd_data !== 8'h00) begin errors++; $display("FAIL async_reset_data: got %h expected 00", rd_data); end
`endif
    tick();
    rst_n = 1'b1;
    tick();
  endtask

`ifdef SYNC_FIFO_FWFT_EN
  task automatic test_fwft();
    push(8'hA5);
    checks++;
    if (rd_data !== 8'hA5 || rd_empty !== 1'b0) begin
      errors++; $display("FAIL fwft_show: data=%h empty=%b expected a5 0", rd_data, rd_empty);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_empty !== 1'b1) begin errors++; $display("FAIL fwft_pop: empty=%b expected 1", rd_empty); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_empty_rw();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
